// File: rtl/mem_port_arbiter.sv
// Arbiter for the single physical-memory port shared by the icache (fetch) and
// the dcache (memory stage). One line transfer is in flight at a time. Address,
// write line and operation are latched at grant. The owner's resp pulses for one
// cycle. D wins ties unless I has been starved for STARVE_MAX consecutive D grants.
module mem_port_arbiter #(
  parameter int unsigned LINE_W     = 256,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // icache side
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  // dcache side
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  // physical memory side
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              busy
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

  typedef enum logic [2:0] {
    StIdle,
    StXferI,
    StXferD,
    StRespI,
    StRespD
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   starve_cnt_q, starve_cnt_d;
  logic              pmem_read_q, pmem_read_d;
  logic              pmem_write_q, pmem_write_d;
  logic [ADDR_W-1:0] pmem_addr_q, pmem_addr_d;
  logic [LINE_W-1:0] pmem_wdata_q, pmem_wdata_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_resp_q, i_resp_d;
  logic              d_resp_q, d_resp_d;
  logic              busy_q, busy_d;

  logic d_req;
  logic grant_i;
  logic grant_d;

  // Grant decision, only meaningful in IDLE; I is forced once starvation saturates.
  always_comb begin
    d_req   = d_read | d_write;
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == StIdle) begin
      if (i_read && d_req) begin
        if (starve_cnt_q == StarveMax) begin
          grant_i = 1'b1;
        end else begin
          grant_d = 1'b1;
        end
      end else if (i_read) begin
        grant_i = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    pmem_read_d  = pmem_read_q;
    pmem_write_d = pmem_write_q;
    pmem_addr_d  = pmem_addr_q;
    pmem_wdata_d = pmem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_resp_d     = 1'b0;
    d_resp_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (grant_i) begin
          state_d      = StXferI;
          pmem_read_d  = 1'b1;
          pmem_write_d = 1'b0;
          pmem_addr_d  = i_addr;
          starve_cnt_d = '0;
        end else if (grant_d) begin
          state_d      = StXferD;
          // A simultaneous read and write from the dcache is a writeback.
          pmem_write_d = d_write;
          pmem_read_d  = ~d_write;
          pmem_addr_d  = d_addr;
          pmem_wdata_d = d_wdata;
          if (i_read && (starve_cnt_q != StarveMax)) begin
            starve_cnt_d = starve_cnt_q + CntW'(1);
          end
        end
      end

      StXferI: begin
        if (pmem_resp) begin
          state_d     = StRespI;
          pmem_read_d = 1'b0;
          i_rdata_d   = pmem_rdata;
          i_resp_d    = 1'b1;
        end
      end

      StXferD: begin
        if (pmem_resp) begin
          state_d      = StRespD;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
          // Writebacks leave the previously returned line untouched.
          if (pmem_read_q) begin
            d_rdata_d = pmem_rdata;
          end
          d_resp_d = 1'b1;
        end
      end

      // The RESP cycle keeps the still-asserted old request from being re-granted.
      StRespI, StRespD: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and output registers; reset drops the pmem strobes immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      starve_cnt_q <= '0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      pmem_addr_q  <= '0;
      pmem_wdata_q <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_resp_q     <= 1'b0;
      d_resp_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      pmem_read_q  <= pmem_read_d;
      pmem_write_q <= pmem_write_d;
      pmem_addr_q  <= pmem_addr_d;
      pmem_wdata_q <= pmem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_resp_q     <= i_resp_d;
      d_resp_q     <= d_resp_d;
      busy_q       <= busy_d;
    end
  end

  assign pmem_read  = pmem_read_q;
  assign pmem_write = pmem_write_q;
  assign pmem_addr  = pmem_addr_q;
  assign pmem_wdata = pmem_wdata_q;
  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign i_resp     = i_resp_q;
  assign d_resp     = d_resp_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a table of single-owner transfers plus hand-written
// sequences for reset abort, simultaneous requests and I starvation. Expected
// responses go into a scoreboard queue when pmem_resp is driven and are popped
// by a monitor when i_resp/d_resp appears.
module tb_mem_port_arbiter;

  localparam int unsigned LW = 256;
  localparam int unsigned AW = 32;

  logic          clk;
  logic          rst_n;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_addr;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;
  logic          busy;

  mem_port_arbiter #(
    .LINE_W     (LW),
    .ADDR_W     (AW),
    .STARVE_MAX (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_read     (i_read),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_addr  (pmem_addr),
    .pmem_wdata (pmem_wdata),
    .pmem_rdata (pmem_rdata),
    .pmem_resp  (pmem_resp),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit            is_d;
    bit            is_wr;
    logic [LW-1:0] rdata;
  } sb_t;

  typedef struct {
    bit            i_rd;
    bit            d_rd;
    bit            d_wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    int            delay;
    logic [LW-1:0] rdata;
    bit            stretch;
    bit            exp_d;
    bit            exp_wr;
  } vec_t;

  sb_t           sb_q[$];
  sb_t           mon_e;
  vec_t          vecs[6];
  int            n_cmp = 0;
  int            n_err = 0;
  logic [LW-1:0] exp_i_rdata = '0;
  logic [LW-1:0] exp_d_rdata = '0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Waits for the pmem strobe, checks it, answers after 'delay' cycles, and
  // returns just after the edge that ends the RESP cycle.
  task automatic serve(input bit exp_d, input bit exp_wr, input logic [AW-1:0] exp_addr,
                       input logic [LW-1:0] exp_wdata, input int delay,
                       input logic [LW-1:0] rdata, input bit stretch, input string tag);
    int  waited = 0;
    bit  seen   = 1'b0;
    sb_t e;
    while (!seen && waited < 20) begin
      @(negedge clk);
      waited++;
      if (pmem_read || pmem_write) seen = 1'b1;
    end
    if (!seen) begin
      check({tag, "_strobe_timeout"}, 256'(0), 256'(1));
      return;
    end
    check({tag, "_strobe_latency"}, 256'(waited), 256'(2));
    check({tag, "_pmem_addr"}, 256'(pmem_addr), 256'(exp_addr));
    check({tag, "_pmem_write"}, 256'(pmem_write), 256'(exp_wr));
    check({tag, "_pmem_read"}, 256'(pmem_read), 256'(!exp_wr));
    if (exp_wr) check({tag, "_pmem_wdata"}, pmem_wdata, exp_wdata);
    check({tag, "_busy"}, 256'(busy), 256'(1));
    for (int n = 0; n < delay; n++) begin
      @(negedge clk);
      check({tag, "_strobe_held"}, 256'({pmem_read, pmem_write}), 256'({!exp_wr, exp_wr}));
    end
    e.is_d  = exp_d;
    e.is_wr = exp_wr;
    e.rdata = rdata;
    sb_q.push_back(e);
    pmem_rdata = rdata;
    pmem_resp  = 1'b1;
    @(negedge clk);
    // Optionally hold pmem_resp through the RESP cycle as a spurious response.
    pmem_resp  = stretch;
    pmem_rdata = {8{$urandom}};
    check({tag, "_strobe_drop"}, 256'({pmem_read, pmem_write}), 256'(0));
    @(posedge clk);
    #1;
    pmem_resp = 1'b0;
    check({tag, "_resp_seen"}, 256'(sb_q.size()), 256'(0));
  endtask

  // Monitor: response exclusivity, scoreboard pops and rdata stability.
  always @(negedge clk) begin
    if (rst_n) begin
      check("resp_exclusive", 256'(i_resp & d_resp), 256'(0));
      check("strobe_exclusive", 256'(pmem_read & pmem_write), 256'(0));
      if (i_resp || d_resp) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_resp: got i_resp=%0b d_resp=%0b, want none", i_resp, d_resp);
        end else begin
          mon_e = sb_q.pop_front();
          check("resp_owner", 256'(d_resp), 256'(mon_e.is_d));
          if (!mon_e.is_d) exp_i_rdata = mon_e.rdata;
          else if (!mon_e.is_wr) exp_d_rdata = mon_e.rdata;
        end
      end
      check("i_rdata", i_rdata, exp_i_rdata);
      check("d_rdata", d_rdata, exp_d_rdata);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    int  w;
    bit  seen;
    logic [LW-1:0] rd;

    vecs[0] = '{i_rd: 1, d_rd: 0, d_wr: 0, addr: 32'h0000_0040, wdata: '0, delay: 3,
                rdata: {32{8'hA5}}, stretch: 0, exp_d: 0, exp_wr: 0};
    vecs[1] = '{i_rd: 0, d_rd: 0, d_wr: 1, addr: 32'h0000_0100, wdata: {8{32'hDEAD_BEEF}},
                delay: 0, rdata: {8{32'hBAD0_BAD0}}, stretch: 0, exp_d: 1, exp_wr: 1};
    vecs[2] = '{i_rd: 0, d_rd: 1, d_wr: 0, addr: 32'h0000_0200, wdata: '0, delay: 1,
                rdata: {8{32'h1234_5678}}, stretch: 0, exp_d: 1, exp_wr: 0};
    vecs[3] = '{i_rd: 0, d_rd: 1, d_wr: 1, addr: 32'h0000_0300, wdata: {8{32'h0F0F_5A5A}},
                delay: 2, rdata: {8{32'hBAD1_BAD1}}, stretch: 0, exp_d: 1, exp_wr: 1};
    vecs[4] = '{i_rd: 0, d_rd: 1, d_wr: 0, addr: 32'h0000_0340, wdata: '0, delay: 4,
                rdata: {8{32'hCAFE_F00D}}, stretch: 0, exp_d: 1, exp_wr: 0};
    vecs[5] = '{i_rd: 1, d_rd: 0, d_wr: 0, addr: 32'h0000_1FC0, wdata: '0, delay: 1,
                rdata: {8{32'h7777_1111}}, stretch: 1, exp_d: 0, exp_wr: 0};

    rst_n      = 1'b0;
    i_read     = 1'b0;
    i_addr     = '0;
    d_read     = 1'b0;
    d_write    = 1'b0;
    d_addr     = '0;
    d_wdata    = '0;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_strobes", 256'({pmem_read, pmem_write}), 256'(0));
    check("rst_resps", 256'({i_resp, d_resp}), 256'(0));
    check("rst_pmem_addr", 256'(pmem_addr), 256'(0));
    check("rst_pmem_wdata", pmem_wdata, 256'(0));
    check("rst_i_rdata", i_rdata, 256'(0));
    check("rst_d_rdata", d_rdata, 256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted mid-writeback must drop everything asynchronously
    @(posedge clk);
    #1;
    d_write = 1'b1;
    d_addr  = 32'h0000_0080;
    d_wdata = {8{32'h5555_AAAA}};
    w    = 0;
    seen = 1'b0;
    while (!seen && w < 20) begin
      @(negedge clk);
      w++;
      if (pmem_write) seen = 1'b1;
    end
    check("abort_pmem_write_up", 256'(pmem_write), 256'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_pmem_write", 256'(pmem_write), 256'(0));
    check("abort_pmem_read", 256'(pmem_read), 256'(0));
    check("abort_busy", 256'(busy), 256'(0));
    check("abort_pmem_addr", 256'(pmem_addr), 256'(0));
    check("abort_pmem_wdata", pmem_wdata, 256'(0));
    d_write = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      check("abort_idle", 256'({busy, d_resp}), 256'(0));
    end

    // Single-owner transfers from the table
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      i_read  = vecs[i].i_rd;
      d_read  = vecs[i].d_rd;
      d_write = vecs[i].d_wr;
      i_addr  = vecs[i].addr;
      d_addr  = vecs[i].addr;
      d_wdata = vecs[i].wdata;
      serve(vecs[i].exp_d, vecs[i].exp_wr, vecs[i].addr, vecs[i].wdata, vecs[i].delay,
            vecs[i].rdata, vecs[i].stretch, $sformatf("vec%0d", i));
      i_read  = 1'b0;
      d_read  = 1'b0;
      d_write = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_idle_after", i), 256'(busy), 256'(0));
    end

    // Spurious pmem_resp while idle
    @(negedge clk);
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    check("spurious_idle_busy", 256'(busy), 256'(0));
    @(negedge clk);
    check("spurious_idle_busy2", 256'(busy), 256'(0));

    // Simultaneous requests with no starvation: D first, then I
    @(posedge clk);
    #1;
    i_read = 1'b1;
    i_addr = 32'h0000_0400;
    d_read = 1'b1;
    d_addr = 32'h0000_0500;
    serve(1'b1, 1'b0, 32'h0000_0500, '0, 1, {8{32'hD00D_0001}}, 1'b0, "both_d");
    d_read = 1'b0;
    serve(1'b0, 1'b0, 32'h0000_0400, '0, 2, {8{32'h1001_1001}}, 1'b0, "both_i");
    i_read = 1'b0;
    @(negedge clk);
    check("both_idle_after", 256'(busy), 256'(0));

    // Starvation: four D grants, forced I, then counter cleared so D wins again
    @(posedge clk);
    #1;
    i_read = 1'b1;
    i_addr = 32'h0000_0600;
    d_read = 1'b1;
    d_addr = 32'h0000_1000;
    for (int j = 0; j < 4; j++) begin
      rd = {8{32'hD000_0000 + 32'(j)}};
      serve(1'b1, 1'b0, 32'h0000_1000 + 32'(j * 32), '0, j % 2, rd, 1'b0,
            $sformatf("starve_d%0d", j));
      d_addr = 32'h0000_1000 + 32'((j + 1) * 32);
    end
    serve(1'b0, 1'b0, 32'h0000_0600, '0, 0, {8{32'h1111_0000}}, 1'b0, "starve_i0");
    i_addr = 32'h0000_0640;
    serve(1'b1, 1'b0, 32'h0000_1080, '0, 1, {8{32'hD000_0004}}, 1'b0, "starve_d4");
    d_addr = 32'h0000_10A0;
    serve(1'b1, 1'b0, 32'h0000_10A0, '0, 0, {8{32'hD000_0005}}, 1'b0, "starve_d5");
    d_read = 1'b0;
    serve(1'b0, 1'b0, 32'h0000_0640, '0, 1, {8{32'h1111_0001}}, 1'b0, "starve_i1");
    i_read = 1'b0;

    repeat (3) @(negedge clk);
    check("final_busy", 256'(busy), 256'(0));
    check("final_sb_empty", 256'(sb_q.size()), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
